// File: rtl/async_rr_arbiter_pkg.sv
// Shared definitions for the round-robin req/ack arbiter family.
// State encoding plus the cyclic scan helper used by rr_pick.
package async_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Index reached after stepping 'offset' places past 'last', wrapping at n.
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/async_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last',
// scanning last+1, last+2, ... and wrapping, with 'last' itself checked last.
module rr_pick
    import async_rr_arbiter_pkg::*;
#(
    parameter int num_req   = 4,
    parameter int idx_width = $clog2(num_req)
) (
    input  logic [num_req-1:0]   req,
    input  logic [idx_width-1:0] last,
    output logic [idx_width-1:0] idx,
    output logic                 any_req
);

    logic [idx_width-1:0] cand;

    always_comb begin
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= num_req; k++) begin
            cand = idx_width'(rr_index(int'(last), k, num_req));
            if (!any_req && req[cand]) begin
                idx     = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_rr_arbiter.sv
// Shares one req/ack source among num_req requesters, one transaction at a
// time, routing the source ack and data only to the round-robin winner.
module async_rr_arbiter
    import async_rr_arbiter_pkg::*;
#(
    parameter int data_width = 32,
    parameter int num_req    = 4,
    parameter int cnt_width  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_req-1:0]             req_i,
    output logic [num_req-1:0]             ack_o,
    output logic [data_width-1:0]          dout,
    output logic                           src_req,
    input  logic                           src_ack,
    input  logic [data_width-1:0]          src_din,
    output logic [num_req*cnt_width-1:0]   grant_count,
    output logic                           busy
);

    localparam int idx_width = $clog2(num_req);

    state_t                 state;
    state_t                 state_next;
    logic [idx_width-1:0]   grant;
    logic [idx_width-1:0]   last;
    logic [idx_width-1:0]   pick_idx;
    logic                   any_req;
    logic [cnt_width-1:0]   count [num_req];

    rr_pick #(
        .num_req   (num_req),
        .idx_width (idx_width)
    ) u_pick (
        .req     (req_i),
        .last    (last),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    // State register and all registered datapath; ack_o self-clears each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            last    <= idx_width'(num_req - 1);
            src_req <= 1'b0;
            ack_o   <= '0;
            dout    <= '0;
            for (int i = 0; i < num_req; i++) begin
                count[i] <= '0;
            end
        end else begin
            state <= state_next;
            ack_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant   <= pick_idx;
                        src_req <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (src_ack) begin
                        dout         <= src_din;
                        ack_o[grant] <= 1'b1;
                        src_req      <= 1'b0;
                        last         <= grant;
                        count[grant] <= count[grant] + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RELEASE holds until the served requester lets go, so a stuck request blocks.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (any_req)         state_next = ST_WAIT;
            ST_WAIT:    if (src_ack)         state_next = ST_RELEASE;
            ST_RELEASE: if (!req_i[grant])   state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        grant_count = '0;
        for (int i = 0; i < num_req; i++) begin
            grant_count[i*cnt_width +: cnt_width] = count[i];
        end
    end

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Scoreboard bench: source/requester models push expected (requester, data)
// pairs; an independent monitor pops them whenever ack_o fires.
module tb_async_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_drv = '0;
    logic [N-1:0]      ack_o;
    logic [DW-1:0]     dout;
    logic              src_req;
    logic              src_ack = 1'b0;
    logic [DW-1:0]     src_din = '0;
    logic [N*CW-1:0]   grant_count;
    logic              busy;

    async_rr_arbiter #(
        .data_width (DW),
        .num_req    (N),
        .cnt_width  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_drv),
        .ack_o       (ack_o),
        .dout        (dout),
        .src_req     (src_req),
        .src_ack     (src_ack),
        .src_din     (src_din),
        .grant_count (grant_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb[$];
    logic [N-1:0]  ack_log[$];
    int            n_compared   = 0;
    int            n_mismatched = 0;

    int            cycle = 0;
    int            ack_total = 0;
    int            produced = 0;
    int            model_last = N - 1;
    int            pending_grant = 0;
    int            wait_cnt = 0;
    int            last_rise = -1;
    bit            check_period = 0;
    bit            spurious_en = 0;
    bit            prev_src_req = 0;
    int            fail_rate = 0;
    int            min_delay = 0;
    int            drop_rate = 0;
    logic [DW-1:0] src_data = '0;
    int            req_prob [N];
    int            hold_cycles [N];
    int            hold_left [N];
    bit            abandoned [N];

    int            exp_count [N];
    sb_t           mon_e;
    logic [N*CW-1:0] mon_model;
    logic [N-1:0]  mon_vec;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Round-robin rule: first requester after 'last' in cyclic order.
    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One clock of requester and source behaviour, driven at the falling edge.
    task automatic apply_stimulus();
        logic [N-1:0] seen_req;
        @(negedge clk);
        cycle++;
        seen_req = req_drv;
        if (src_req && !prev_src_req) begin
            pending_grant = rr_next(seen_req, model_last);
            model_last    = pending_grant;
            check_output("decision_has_request", 64'(pending_grant >= 0), 64'(1));
            if (check_period && last_rise >= 0)
                check_output("cycles_per_item", 64'(cycle - last_rise), 64'(4));
            last_rise = cycle;
        end
        if (prev_src_req && !src_ack && !rst)
            check_output("src_req_held", 64'(src_req), 64'(1));
        if (ack_o != '0) begin
            ack_total++;
            ack_log.push_back(ack_o);
        end
        if (src_ack) begin
            src_ack = 1'b0;
        end else if (src_req) begin
            if (wait_cnt >= min_delay && int'($urandom_range(99)) >= fail_rate) begin
                src_ack  = 1'b1;
                src_din  = src_data;
                sb.push_back('{idx: pending_grant, data: src_data});
                src_data = src_data + 1'b1;
                produced++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else if (spurious_en && $urandom_range(7) == 0) begin
            src_ack = 1'b1;
            src_din = DW'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            if (ack_o[i]) begin
                abandoned[i] = 0;
                if (req_drv[i] && hold_cycles[i] > 0) hold_left[i] = hold_cycles[i];
                else req_drv[i] = 1'b0;
            end else if (hold_left[i] > 0) begin
                check_output("release_busy", 64'(busy), 64'(1));
                check_output("release_no_src_req", 64'(src_req), 64'(0));
                hold_left[i]--;
                if (hold_left[i] == 0) req_drv[i] = 1'b0;
            end else if (req_drv[i]) begin
                if (src_req && i == pending_grant && int'($urandom_range(99)) < drop_rate) begin
                    req_drv[i]   = 1'b0;
                    abandoned[i] = 1;
                end
            end else if (!abandoned[i] && int'($urandom_range(99)) < req_prob[i]) begin
                req_drv[i] = 1'b1;
            end
        end
        prev_src_req = src_req;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cycle++;
        rst     = 1'b1;
        src_ack = 1'b0;
        sb.delete();
        model_last = N - 1;
        wait_cnt   = 0;
        produced   = 0;
        last_rise  = -1;
        for (int i = 0; i < N; i++) begin
            hold_left[i] = 0;
            abandoned[i] = 0;
        end
        @(negedge clk);
        cycle++;
        check_output("rst_src_req", 64'(src_req), 64'(0));
        check_output("rst_ack_o", 64'(ack_o), 64'(0));
        check_output("rst_dout", 64'(dout), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_grant_count", 64'(grant_count), 64'(0));
        rst = 1'b0;
        prev_src_req = src_req;
    endtask

    task automatic run_acks(input string name, input int n, input int budget);
        int target;
        int c;
        target = ack_total + n;
        c = 0;
        while (ack_total < target && c < budget) begin
            apply_stimulus();
            c++;
        end
        if (ack_total < target) check_output(name, 64'(ack_total), 64'(target));
    endtask

    task automatic wait_src_req(input string name, input int budget);
        int c;
        c = 0;
        while (!src_req && c < budget) begin
            apply_stimulus();
            c++;
        end
        if (!src_req) check_output(name, 64'(src_req), 64'(1));
    endtask

    task automatic settle(input string name);
        int c;
        for (int i = 0; i < N; i++) req_prob[i] = 0;
        spurious_en = 0;
        drop_rate   = 0;
        c = 0;
        apply_stimulus();
        while ((busy || req_drv != '0 || src_ack) && c < 300) begin
            apply_stimulus();
            c++;
        end
        if (busy || req_drv != '0) check_output(name, 64'(busy), 64'(0));
    endtask

    task automatic set_probs(input int p0, input int p1, input int p2, input int p3);
        req_prob[0] = p0;
        req_prob[1] = p1;
        req_prob[2] = p2;
        req_prob[3] = p3;
    endtask

    // Monitor: pops the scoreboard on every ack pulse, just after the rising edge.
    initial begin
        for (int i = 0; i < N; i++) exp_count[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < N; i++) exp_count[i] = 0;
            end else if (ack_o != '0) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_ack", 64'(ack_o), 64'(0));
                end else begin
                    mon_e   = sb.pop_front();
                    mon_vec = '0;
                    if (mon_e.idx >= 0 && mon_e.idx < N) begin
                        mon_vec[mon_e.idx] = 1'b1;
                        exp_count[mon_e.idx] = (exp_count[mon_e.idx] + 1) % (1 << CW);
                    end
                    for (int i = 0; i < N; i++) mon_model[i*CW +: CW] = CW'(exp_count[i]);
                    check_output("ack_target", 64'(ack_o), 64'(mon_vec));
                    check_output("dout", 64'(dout), 64'(mon_e.data));
                    check_output("grant_count", 64'(grant_count), 64'(mon_model));
                end
            end
        end
    end

    initial begin
        int sum;
        int exp_order [3];
        logic [N-1:0] got;
        for (int i = 0; i < N; i++) begin
            req_prob[i]    = 0;
            hold_cycles[i] = 0;
            hold_left[i]   = 0;
            abandoned[i]   = 0;
        end
        do_reset();

        // Single requester 0, source answers one cycle after src_req.
        $display("[TB] single requester");
        set_probs(100, 0, 0, 0);
        min_delay    = 1;
        check_period = 1;
        run_acks("timeout_single", 12, 200);
        check_period = 0;
        settle("settle_single");
        check_output("single_count0", 64'(grant_count[0 +: CW]), 64'(12));

        // All four requesting continuously; counters reach 100, then wrap.
        $display("[TB] all requesting");
        do_reset();
        set_probs(100, 100, 100, 100);
        min_delay = 0;
        run_acks("timeout_all_400", 400, 2000);
        for (int i = 0; i < N; i++)
            check_output("count_after_400", 64'(grant_count[i*CW +: CW]), 64'(100));
        run_acks("timeout_all_1200", 800, 4000);
        for (int i = 0; i < N; i++)
            check_output("count_wrapped", 64'(grant_count[i*CW +: CW]), 64'(300 % 256));
        settle("settle_all");

        // Requester 2 alone, then 1 and 3 join while 2 waits on the source.
        $display("[TB] late joiners");
        do_reset();
        set_probs(0, 0, 0, 0);
        fail_rate = 100;
        req_drv   = 4'b0100;
        wait_src_req("timeout_join_wait", 20);
        req_drv[1] = 1'b1;
        req_drv[3] = 1'b1;
        fail_rate  = 0;
        ack_log.delete();
        run_acks("timeout_join", 3, 100);
        exp_order[0] = 2;
        exp_order[1] = 3;
        exp_order[2] = 1;
        for (int k = 0; k < 3; k++) begin
            got = (k < ack_log.size()) ? ack_log[k] : '0;
            check_output("join_order", 64'(got), 64'(1 << exp_order[k]));
        end
        settle("settle_join");

        // Slow source, random requests, withdrawals and stray acks.
        $display("[TB] random traffic");
        do_reset();
        set_probs(30, 30, 30, 30);
        fail_rate   = 50;
        spurious_en = 1;
        drop_rate   = 10;
        run_acks("timeout_random", 300, 20000);
        settle("settle_random");
        fail_rate = 0;
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(grant_count[i*CW +: CW]);
        check_output("count_sum", 64'(sum), 64'(produced));

        // Requester 1 keeps its request 5 cycles past each ack.
        $display("[TB] hold after ack");
        do_reset();
        set_probs(0, 100, 0, 0);
        hold_cycles[1] = 5;
        run_acks("timeout_hold", 3, 200);
        settle("settle_hold");
        hold_cycles[1] = 0;

        // Reset while waiting on the source; first grant afterwards is requester 0.
        $display("[TB] reset in wait");
        fail_rate = 100;
        req_drv   = 4'b0100;
        wait_src_req("timeout_rst_wait", 20);
        req_drv = 4'b1111;
        do_reset();
        fail_rate = 0;
        ack_log.delete();
        run_acks("timeout_rst_first", 1, 50);
        got = (ack_log.size() > 0) ? ack_log[0] : '0;
        check_output("post_reset_first_grant", 64'(got), 64'(1));
        settle("settle_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
